// File: rtl/rob.sv
// Reorder buffer: dual-slot in-order allocate, dual CDB writeback, four operand
// lookups with same-cycle bypass, and up to two in-order commits per cycle.
module rob #(
    parameter int unsigned  ROB_ENTRIES   = 16,
    parameter int unsigned  CPU_DATA_BITS = 32,
    parameter int unsigned  ARCH_REGS     = 32,
    localparam int unsigned TAG_WIDTH     = $clog2(ROB_ENTRIES),
    localparam int unsigned RD_W          = $clog2(ARCH_REGS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     alloc_valid_0,
    input  logic                     alloc_valid_1,
    input  logic [RD_W-1:0]          alloc_rd_0,
    input  logic [RD_W-1:0]          alloc_rd_1,
    input  logic                     alloc_has_rd_0,
    input  logic                     alloc_has_rd_1,
    output logic                     alloc_ready,
    output logic [TAG_WIDTH-1:0]     alloc_tag_0,
    output logic [TAG_WIDTH-1:0]     alloc_tag_1,
    input  logic                     cdb_valid_0,
    input  logic                     cdb_valid_1,
    input  logic [TAG_WIDTH-1:0]     cdb_tag_0,
    input  logic [TAG_WIDTH-1:0]     cdb_tag_1,
    input  logic [CPU_DATA_BITS-1:0] cdb_data_0,
    input  logic [CPU_DATA_BITS-1:0] cdb_data_1,
    input  logic [TAG_WIDTH-1:0]     src_tag_0,
    input  logic [TAG_WIDTH-1:0]     src_tag_1,
    input  logic [TAG_WIDTH-1:0]     src_tag_2,
    input  logic [TAG_WIDTH-1:0]     src_tag_3,
    output logic                     src_done_0,
    output logic                     src_done_1,
    output logic                     src_done_2,
    output logic                     src_done_3,
    output logic [CPU_DATA_BITS-1:0] src_data_0,
    output logic [CPU_DATA_BITS-1:0] src_data_1,
    output logic [CPU_DATA_BITS-1:0] src_data_2,
    output logic [CPU_DATA_BITS-1:0] src_data_3,
    output logic                     commit_0_valid,
    output logic                     commit_0_we,
    output logic [RD_W-1:0]          commit_0_addr,
    output logic [TAG_WIDTH-1:0]     commit_0_tag,
    output logic [CPU_DATA_BITS-1:0] commit_0_data,
    output logic                     commit_1_valid,
    output logic                     commit_1_we,
    output logic [RD_W-1:0]          commit_1_addr,
    output logic [TAG_WIDTH-1:0]     commit_1_tag,
    output logic [CPU_DATA_BITS-1:0] commit_1_data,
    output logic                     empty,
    output logic                     full
);

    localparam int unsigned PTR_W = TAG_WIDTH + 1;

    logic [ROB_ENTRIES-1:0]   valid_q, valid_d, done_q, done_d, has_rd_q, has_rd_d;
    logic [RD_W-1:0]          rd_q   [ROB_ENTRIES];
    logic [RD_W-1:0]          rd_d   [ROB_ENTRIES];
    logic [CPU_DATA_BITS-1:0] data_q [ROB_ENTRIES];
    logic [CPU_DATA_BITS-1:0] data_d [ROB_ENTRIES];
    logic [PTR_W-1:0]         head_q, head_d, tail_q, tail_d, count_q, count_d;

    logic [TAG_WIDTH-1:0]     head_idx, head1_idx, tail_idx;
    logic                     do_alloc_0, do_alloc_1;
    logic [PTR_W-1:0]         n_alloc, n_commit;

    logic [TAG_WIDTH-1:0]     src_tag  [4];
    logic                     src_done [4];
    logic [CPU_DATA_BITS-1:0] src_data [4];

    assign head_idx  = head_q[TAG_WIDTH-1:0];
    assign head1_idx = head_idx + TAG_WIDTH'(1);
    assign tail_idx  = tail_q[TAG_WIDTH-1:0];

    // Allocation handshake: credit comes from the registered count only
    assign alloc_ready = (count_q <= PTR_W'(ROB_ENTRIES - 2)) && !flush;
    assign alloc_tag_0 = tail_idx;
    assign alloc_tag_1 = tail_idx + TAG_WIDTH'(alloc_valid_0);
    assign do_alloc_0  = alloc_ready && alloc_valid_0;
    assign do_alloc_1  = alloc_ready && alloc_valid_1;

    assign empty = (count_q == '0);
    assign full  = (count_q == PTR_W'(ROB_ENTRIES));

    // In-order retirement of the two oldest entries
    assign commit_0_valid = valid_q[head_idx] && done_q[head_idx] && !flush && !rst;
    assign commit_1_valid = commit_0_valid && valid_q[head1_idx] && done_q[head1_idx];
    assign commit_0_we    = commit_0_valid && has_rd_q[head_idx];
    assign commit_1_we    = commit_1_valid && has_rd_q[head1_idx];
    assign commit_0_addr  = rd_q[head_idx];
    assign commit_1_addr  = rd_q[head1_idx];
    assign commit_0_tag   = head_idx;
    assign commit_1_tag   = head1_idx;
    assign commit_0_data  = data_q[head_idx];
    assign commit_1_data  = data_q[head1_idx];

    assign n_alloc  = PTR_W'(do_alloc_0) + PTR_W'(do_alloc_1);
    assign n_commit = PTR_W'(commit_0_valid) + PTR_W'(commit_1_valid);

    assign src_tag[0] = src_tag_0;
    assign src_tag[1] = src_tag_1;
    assign src_tag[2] = src_tag_2;
    assign src_tag[3] = src_tag_3;

    // Operand lookup with CDB bypass; port 1 has priority over port 0
    always_comb begin
        for (int j = 0; j < 4; j++) begin
            src_done[j] = valid_q[src_tag[j]] && done_q[src_tag[j]];
            src_data[j] = data_q[src_tag[j]];
            if (cdb_valid_0 && (cdb_tag_0 == src_tag[j]) && valid_q[src_tag[j]]) begin
                src_done[j] = 1'b1;
                src_data[j] = cdb_data_0;
            end
            if (cdb_valid_1 && (cdb_tag_1 == src_tag[j]) && valid_q[src_tag[j]]) begin
                src_done[j] = 1'b1;
                src_data[j] = cdb_data_1;
            end
        end
    end

    assign src_done_0 = src_done[0];
    assign src_done_1 = src_done[1];
    assign src_done_2 = src_done[2];
    assign src_done_3 = src_done[3];
    assign src_data_0 = src_data[0];
    assign src_data_1 = src_data[1];
    assign src_data_2 = src_data[2];
    assign src_data_3 = src_data[3];

    // Next state: writeback, then retire, then allocate (slots never overlap)
    always_comb begin
        valid_d  = valid_q;
        done_d   = done_q;
        has_rd_d = has_rd_q;
        rd_d     = rd_q;
        data_d   = data_q;
        head_d   = head_q + n_commit;
        tail_d   = tail_q + n_alloc;
        count_d  = count_q + n_alloc - n_commit;

        if (cdb_valid_0 && valid_q[cdb_tag_0]) begin
            done_d[cdb_tag_0] = 1'b1;
            data_d[cdb_tag_0] = cdb_data_0;
        end
        if (cdb_valid_1 && valid_q[cdb_tag_1]) begin
            done_d[cdb_tag_1] = 1'b1;
            data_d[cdb_tag_1] = cdb_data_1;
        end
        if (commit_0_valid) valid_d[head_idx]  = 1'b0;
        if (commit_1_valid) valid_d[head1_idx] = 1'b0;
        if (do_alloc_0) begin
            valid_d[alloc_tag_0]  = 1'b1;
            done_d[alloc_tag_0]   = 1'b0;
            has_rd_d[alloc_tag_0] = alloc_has_rd_0 && (alloc_rd_0 != '0);
            rd_d[alloc_tag_0]     = alloc_rd_0;
        end
        if (do_alloc_1) begin
            valid_d[alloc_tag_1]  = 1'b1;
            done_d[alloc_tag_1]   = 1'b0;
            has_rd_d[alloc_tag_1] = alloc_has_rd_1 && (alloc_rd_1 != '0);
            rd_d[alloc_tag_1]     = alloc_rd_1;
        end

        if (flush) begin
            valid_d = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= '0;
            done_q   <= '0;
            has_rd_q <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            for (int i = 0; i < ROB_ENTRIES; i++) begin
                rd_q[i]   <= '0;
                data_q[i] <= '0;
            end
        end else begin
            valid_q  <= valid_d;
            done_q   <= done_d;
            has_rd_q <= has_rd_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            rd_q     <= rd_d;
            data_q   <= data_d;
        end
    end

endmodule

// File: tb/tb_rob.sv
// Self-checking bench for rob: allocation-pattern table plus directed sequences;
// retirements are checked against a scoreboard filled at allocation time.
module tb_rob;

    typedef struct packed {
        logic        we;
        logic [4:0]  addr;
        logic [3:0]  tag;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic       v0, v1;
        logic [4:0] rd0, rd1;
        logic       h0, h1;
        logic [3:0] t0, t1;
    } vec_t;

    logic        clk = 1'b0, rst = 1'b1, flush = 1'b0;
    logic        alloc_valid_0, alloc_valid_1, alloc_has_rd_0, alloc_has_rd_1;
    logic [4:0]  alloc_rd_0, alloc_rd_1;
    logic        alloc_ready, empty, full;
    logic [3:0]  alloc_tag_0, alloc_tag_1;
    logic        cdb_valid_0, cdb_valid_1;
    logic [3:0]  cdb_tag_0, cdb_tag_1;
    logic [31:0] cdb_data_0, cdb_data_1;
    logic [3:0]  src_tag_0, src_tag_1, src_tag_2, src_tag_3;
    logic        src_done_0, src_done_1, src_done_2, src_done_3;
    logic [31:0] src_data_0, src_data_1, src_data_2, src_data_3;
    logic        commit_0_valid, commit_0_we, commit_1_valid, commit_1_we;
    logic [4:0]  commit_0_addr, commit_1_addr;
    logic [3:0]  commit_0_tag, commit_1_tag;
    logic [31:0] commit_0_data, commit_1_data;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb[$];
    vec_t tbl[6];

    rob dut (
        .clk(clk), .rst(rst), .flush(flush),
        .alloc_valid_0(alloc_valid_0), .alloc_valid_1(alloc_valid_1),
        .alloc_rd_0(alloc_rd_0), .alloc_rd_1(alloc_rd_1),
        .alloc_has_rd_0(alloc_has_rd_0), .alloc_has_rd_1(alloc_has_rd_1),
        .alloc_ready(alloc_ready), .alloc_tag_0(alloc_tag_0), .alloc_tag_1(alloc_tag_1),
        .cdb_valid_0(cdb_valid_0), .cdb_valid_1(cdb_valid_1),
        .cdb_tag_0(cdb_tag_0), .cdb_tag_1(cdb_tag_1),
        .cdb_data_0(cdb_data_0), .cdb_data_1(cdb_data_1),
        .src_tag_0(src_tag_0), .src_tag_1(src_tag_1), .src_tag_2(src_tag_2), .src_tag_3(src_tag_3),
        .src_done_0(src_done_0), .src_done_1(src_done_1), .src_done_2(src_done_2), .src_done_3(src_done_3),
        .src_data_0(src_data_0), .src_data_1(src_data_1), .src_data_2(src_data_2), .src_data_3(src_data_3),
        .commit_0_valid(commit_0_valid), .commit_0_we(commit_0_we), .commit_0_addr(commit_0_addr),
        .commit_0_tag(commit_0_tag), .commit_0_data(commit_0_data),
        .commit_1_valid(commit_1_valid), .commit_1_we(commit_1_we), .commit_1_addr(commit_1_addr),
        .commit_1_tag(commit_1_tag), .commit_1_data(commit_1_data),
        .empty(empty), .full(full)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic clear_in();
        alloc_valid_0 = 1'b0; alloc_valid_1 = 1'b0;
        alloc_rd_0 = '0; alloc_rd_1 = '0; alloc_has_rd_0 = 1'b0; alloc_has_rd_1 = 1'b0;
        cdb_valid_0 = 1'b0; cdb_valid_1 = 1'b0;
        cdb_tag_0 = '0; cdb_tag_1 = '0; cdb_data_0 = '0; cdb_data_1 = '0;
        src_tag_0 = '0; src_tag_1 = '0; src_tag_2 = '0; src_tag_3 = '0;
    endtask

    task automatic push(input logic has, input logic [4:0] rd, input logic [3:0] tag,
                        input logic [31:0] data);
        exp_t e;
        e.we   = has && (rd != 5'd0);
        e.addr = rd;
        e.tag  = tag;
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic pop_cmp(input string nm, input exp_t act);
        exp_t e;
        if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: unexpected retirement tag %0d, none required", nm, act.tag);
        end else begin
            e = sb.pop_front();
            chk(nm, 64'(act), 64'(e));
        end
    endtask

    // Settle, compare any retirements against the scoreboard, then clock once
    task automatic step();
        #1;
        if (commit_1_valid && !commit_0_valid) chk("commit1_without_commit0", 64'(1), 64'(0));
        if (commit_0_valid) pop_cmp("commit_0", {commit_0_we, commit_0_addr, commit_0_tag, commit_0_data});
        if (commit_1_valid) pop_cmp("commit_1", {commit_1_we, commit_1_addr, commit_1_tag, commit_1_data});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_in();
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 12 && sb.size() != 0; i++) step();
        chk({nm, "_scoreboard_left"}, 64'(sb.size()), 64'(0));
        #1;
        chk({nm, "_empty"}, 64'(empty), 64'(1));
    endtask

    initial begin
        tbl[0] = '{1'b1, 1'b1, 5'd3,  5'd4,  1'b1, 1'b1, 4'd0, 4'd1};
        tbl[1] = '{1'b1, 1'b0, 5'd0,  5'd0,  1'b1, 1'b0, 4'd2, 4'd3};
        tbl[2] = '{1'b0, 1'b1, 5'd0,  5'd7,  1'b0, 1'b1, 4'd3, 4'd3};
        tbl[3] = '{1'b1, 1'b1, 5'd9,  5'd10, 1'b0, 1'b1, 4'd4, 4'd5};
        tbl[4] = '{1'b0, 1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 4'd6, 4'd6};
        tbl[5] = '{1'b1, 1'b1, 5'd31, 5'd1,  1'b1, 1'b1, 4'd6, 4'd7};

        // Reset state
        do_reset();
        #1;
        chk("rst_empty", 64'(empty), 64'(1));
        chk("rst_full", 64'(full), 64'(0));
        chk("rst_alloc_ready", 64'(alloc_ready), 64'(1));
        chk("rst_alloc_tag_0", 64'(alloc_tag_0), 64'(0));
        chk("rst_commit_valid", 64'({commit_0_valid, commit_1_valid, commit_0_we, commit_1_we}), 64'(0));
        chk("rst_src_done", 64'({src_done_0, src_done_1, src_done_2, src_done_3}), 64'(0));
        alloc_valid_0 = 1'b1;
        #1;
        chk("rst_alloc_tag_1", 64'(alloc_tag_1), 64'(1));
        alloc_valid_0 = 1'b0;

        // Basic pair: out-of-order writeback, retire together
        alloc_valid_0 = 1'b1; alloc_valid_1 = 1'b1;
        alloc_rd_0 = 5'd5; alloc_rd_1 = 5'd6; alloc_has_rd_0 = 1'b1; alloc_has_rd_1 = 1'b1;
        #1;
        chk("pair_tag_0", 64'(alloc_tag_0), 64'(0));
        chk("pair_tag_1", 64'(alloc_tag_1), 64'(1));
        push(1'b1, 5'd5, 4'd0, 32'hAA);
        push(1'b1, 5'd6, 4'd1, 32'hBB);
        step();
        clear_in();
        cdb_valid_0 = 1'b1; cdb_tag_0 = 4'd1; cdb_data_0 = 32'hBB;
        #1;
        chk("pair_not_empty", 64'(empty), 64'(0));
        chk("pair_no_commit_early", 64'(commit_0_valid), 64'(0));
        step();
        cdb_tag_0 = 4'd0; cdb_data_0 = 32'hAA;
        #1;
        chk("pair_no_commit_same_cycle", 64'(commit_0_valid), 64'(0));
        step();
        clear_in();
        #1;
        chk("pair_dual_commit", 64'({commit_0_valid, commit_1_valid}), 64'(3));
        step();
        chk("pair_empty_after", 64'(empty), 64'(1));

        // Table of allocation patterns, then writeback with bypass checks
        do_reset();
        for (int i = 0; i < 6; i++) begin
            alloc_valid_0 = tbl[i].v0; alloc_valid_1 = tbl[i].v1;
            alloc_rd_0 = tbl[i].rd0; alloc_rd_1 = tbl[i].rd1;
            alloc_has_rd_0 = tbl[i].h0; alloc_has_rd_1 = tbl[i].h1;
            #1;
            chk($sformatf("tbl%0d_tag_0", i), 64'(alloc_tag_0), 64'(tbl[i].t0));
            chk($sformatf("tbl%0d_tag_1", i), 64'(alloc_tag_1), 64'(tbl[i].t1));
            chk($sformatf("tbl%0d_ready", i), 64'(alloc_ready), 64'(1));
            if (tbl[i].v0) push(tbl[i].h0, tbl[i].rd0, tbl[i].t0, 32'hC0DE_0000 + 32'(tbl[i].t0));
            if (tbl[i].v1) push(tbl[i].h1, tbl[i].rd1, tbl[i].t1, 32'hC0DE_0000 + 32'(tbl[i].t1));
            step();
        end
        clear_in();
        for (int t = 7; t >= 1; t -= 2) begin
            cdb_valid_0 = 1'b1; cdb_tag_0 = 4'(t);     cdb_data_0 = 32'hC0DE_0000 + 32'(t);
            cdb_valid_1 = 1'b1; cdb_tag_1 = 4'(t - 1); cdb_data_1 = 32'hC0DE_0000 + 32'(t - 1);
            src_tag_0 = 4'(t); src_tag_1 = 4'(t - 1); src_tag_2 = 4'(t + 1);
            #1;
            chk($sformatf("byp%0d_p0", t), 64'({src_done_0, src_data_0}), 64'({1'b1, 32'hC0DE_0000 + 32'(t)}));
            chk($sformatf("byp%0d_p1", t), 64'({src_done_1, src_data_1}), 64'({1'b1, 32'hC0DE_0000 + 32'(t - 1)}));
            if (t < 7)
                chk($sformatf("reg%0d_p2", t), 64'({src_done_2, src_data_2}), 64'({1'b1, 32'hC0DE_0000 + 32'(t + 1)}));
            chk($sformatf("wb%0d_no_commit", t), 64'(commit_0_valid), 64'(0));
            step();
        end
        clear_in();
        drain("tbl");

        // Fill to 15: credit drops, request ignored, two retirements restore credit
        do_reset();
        for (int c = 0; c < 7; c++) begin
            alloc_valid_0 = 1'b1; alloc_valid_1 = 1'b1;
            alloc_rd_0 = 5'(2 * c + 1); alloc_rd_1 = 5'(2 * c + 2);
            alloc_has_rd_0 = 1'b1; alloc_has_rd_1 = 1'b1;
            #1;
            chk($sformatf("fill%0d_ready", c), 64'(alloc_ready), 64'(1));
            push(1'b1, 5'(2 * c + 1), 4'(2 * c), 32'h100 + 32'(2 * c));
            push(1'b1, 5'(2 * c + 2), 4'(2 * c + 1), 32'h100 + 32'(2 * c + 1));
            step();
        end
        clear_in();
        alloc_valid_0 = 1'b1; alloc_rd_0 = 5'd15; alloc_has_rd_0 = 1'b1;
        #1;
        chk("fill14_ready", 64'(alloc_ready), 64'(1));
        push(1'b1, 5'd15, 4'd14, 32'h10E);
        step();
        clear_in();
        #1;
        chk("fill15_ready", 64'(alloc_ready), 64'(0));
        chk("fill15_full", 64'(full), 64'(0));
        chk("fill15_tag_0", 64'(alloc_tag_0), 64'(15));
        alloc_valid_0 = 1'b1; alloc_valid_1 = 1'b1; alloc_rd_0 = 5'd20; alloc_has_rd_0 = 1'b1;
        step();
        clear_in();
        #1;
        chk("fill_ignored_tag_0", 64'(alloc_tag_0), 64'(15));
        cdb_valid_0 = 1'b1; cdb_tag_0 = 4'd0; cdb_data_0 = 32'h100;
        cdb_valid_1 = 1'b1; cdb_tag_1 = 4'd1; cdb_data_1 = 32'h101;
        step();
        clear_in();
        #1;
        chk("fill_commit_pair", 64'({commit_0_valid, commit_1_valid}), 64'(3));
        chk("fill_ready_same_cycle", 64'(alloc_ready), 64'(0));
        step();
        chk("fill_ready_after_commit", 64'(alloc_ready), 64'(1));
        for (int t = 2; t < 15; t += 2) begin
            cdb_valid_0 = 1'b1; cdb_tag_0 = 4'(t); cdb_data_0 = 32'h100 + 32'(t);
            cdb_valid_1 = (t + 1 < 15); cdb_tag_1 = 4'(t + 1); cdb_data_1 = 32'h100 + 32'(t + 1);
            step();
        end
        clear_in();
        drain("fill");

        // Wrap-around: 20 single entries retired one by one
        do_reset();
        for (int i = 0; i < 20; i++) begin
            alloc_valid_0 = 1'b1; alloc_rd_0 = 5'((i % 31) + 1); alloc_has_rd_0 = 1'b1;
            #1;
            chk($sformatf("wrap%0d_tag", i), 64'(alloc_tag_0), 64'(i % 16));
            push(1'b1, 5'((i % 31) + 1), 4'(i % 16), 32'h2000 + 32'(i));
            step();
            clear_in();
            cdb_valid_0 = 1'b1; cdb_tag_0 = 4'(i % 16); cdb_data_0 = 32'h2000 + 32'(i);
            step();
            clear_in();
            #1;
            chk($sformatf("wrap%0d_commit", i), 64'(commit_0_valid), 64'(1));
            step();
        end
        chk("wrap_scoreboard_left", 64'(sb.size()), 64'(0));

        // Bypass, port priority, stale writeback, rd=0 retirement
        do_reset();
        alloc_valid_0 = 1'b1; alloc_valid_1 = 1'b1; alloc_has_rd_0 = 1'b1; alloc_has_rd_1 = 1'b1;
        alloc_rd_0 = 5'd1; alloc_rd_1 = 5'd2;
        push(1'b1, 5'd1, 4'd0, 32'hA0);
        push(1'b1, 5'd2, 4'd1, 32'hA1);
        step();
        alloc_rd_0 = 5'd2; alloc_rd_1 = 5'd0;
        push(1'b1, 5'd2, 4'd2, 32'h20);
        push(1'b1, 5'd0, 4'd3, 32'h55);
        step();
        clear_in();
        cdb_valid_0 = 1'b1; cdb_tag_0 = 4'd3; cdb_data_0 = 32'h55; src_tag_2 = 4'd3;
        #1;
        chk("byp_src2", 64'({src_done_2, src_data_2}), 64'({1'b1, 32'h55}));
        step();
        clear_in();
        cdb_valid_0 = 1'b1; cdb_tag_0 = 4'd2; cdb_data_0 = 32'h10;
        cdb_valid_1 = 1'b1; cdb_tag_1 = 4'd2; cdb_data_1 = 32'h20; src_tag_1 = 4'd2;
        #1;
        chk("byp_port1_wins", 64'(src_data_1), 64'(32'h20));
        step();
        clear_in();
        cdb_valid_0 = 1'b1; cdb_tag_0 = 4'd9; cdb_data_0 = 32'h99;
        step();
        clear_in();
        src_tag_0 = 4'd9; src_tag_1 = 4'd2; src_tag_3 = 4'd3;
        #1;
        chk("stale_invalid_tag", 64'(src_done_0), 64'(0));
        chk("reg_port1_wins", 64'({src_done_1, src_data_1}), 64'({1'b1, 32'h20}));
        chk("reg_tag3", 64'({src_done_3, src_data_3}), 64'({1'b1, 32'h55}));
        cdb_valid_0 = 1'b1; cdb_tag_0 = 4'd0; cdb_data_0 = 32'hA0;
        cdb_valid_1 = 1'b1; cdb_tag_1 = 4'd1; cdb_data_1 = 32'hA1;
        step();
        clear_in();
        drain("byp");

        // Flush with completed head entries and a pending allocation
        do_reset();
        for (int c = 0; c < 3; c++) begin
            alloc_valid_0 = 1'b1; alloc_valid_1 = 1'b1; alloc_has_rd_0 = 1'b1; alloc_has_rd_1 = 1'b1;
            alloc_rd_0 = 5'(c + 1); alloc_rd_1 = 5'(c + 10);
            step();
        end
        clear_in();
        cdb_valid_0 = 1'b1; cdb_tag_0 = 4'd0; cdb_data_0 = 32'h1;
        cdb_valid_1 = 1'b1; cdb_tag_1 = 4'd1; cdb_data_1 = 32'h2;
        step();
        clear_in();
        flush = 1'b1; alloc_valid_0 = 1'b1; alloc_valid_1 = 1'b1;
        #1;
        chk("flush_no_commit", 64'({commit_0_valid, commit_0_we, commit_1_valid, commit_1_we}), 64'(0));
        chk("flush_ready", 64'(alloc_ready), 64'(0));
        step();
        flush = 1'b0;
        clear_in();
        #1;
        chk("flush_empty", 64'(empty), 64'(1));
        chk("flush_tag_0", 64'(alloc_tag_0), 64'(0));
        cdb_valid_0 = 1'b1; cdb_tag_0 = 4'd3; cdb_data_0 = 32'h77;
        step();
        clear_in();
        src_tag_0 = 4'd3;
        #1;
        chk("flush_late_cdb", 64'(src_done_0), 64'(0));
        chk("flush_still_empty", 64'(empty), 64'(1));

        // Reset in the middle of a pending retirement
        alloc_valid_0 = 1'b1; alloc_valid_1 = 1'b1; alloc_rd_0 = 5'd4; alloc_has_rd_0 = 1'b1;
        step();
        clear_in();
        cdb_valid_0 = 1'b1; cdb_tag_0 = 4'd0; cdb_data_0 = 32'h5;
        cdb_valid_1 = 1'b1; cdb_tag_1 = 4'd1; cdb_data_1 = 32'h6;
        step();
        clear_in();
        #1;
        chk("midrst_pending", 64'(commit_0_valid), 64'(1));
        rst = 1'b1;
        #1;
        chk("midrst_no_commit", 64'({commit_0_valid, commit_1_valid}), 64'(0));
        step();
        rst = 1'b0;
        #1;
        chk("midrst_empty", 64'(empty), 64'(1));
        chk("midrst_ready", 64'(alloc_ready), 64'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
